cfu_mac_accumulator: RTL and testbench

//  Pipelined 4-lane int8 multiply-accumulate stage directly upstream of the quantizer.

---
 rtl/cfu_mac_accumulator.sv | 131 +++++++++++++
 tb/tb_cfu_mac_accumulator.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfu_mac_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : cfu_mac_accumulator
// Brief    : Two-stage 4-lane int8 MAC with offset, 32-bit wrapping accumulator,
//            saturating beat count and valid/ready result handshake.
// Revision : 1.0 - initial release
// ============================================================================
module cfu_mac_accumulator #(
    parameter int LANES = 4,
    parameter int ACC_W = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [8:0]           input_offset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   in_act,
    input  logic [8*LANES-1:0]   in_filt,
    input  logic                 in_last,
    input  logic                 clear,
    output logic                 acc_valid,
    input  logic                 acc_ready,
    output logic [ACC_W-1:0]     acc_out,
    output logic [CNT_W-1:0]     acc_beats
);

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_BEATS_MAX = '1;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_accept;
    logic               w_release;
    logic [17:0]        w_prod [LANES];
    logic [17:0]        r_prod [LANES];
    logic               r_p_valid;
    logic               r_p_last;
    logic [19:0]        w_lane_sum;
    logic [ACC_W-1:0]   w_acc_inc;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_beats;

    assign in_ready  = (r_state == ST_ACCUM) & ~rst;
    assign acc_valid = (r_state == ST_HOLD);
    assign acc_out   = r_acc;
    assign acc_beats = r_beats;
    assign w_accept  = in_valid & in_ready;
    assign w_release = acc_valid & acc_ready;

    // (act + offset) fits 10b signed; its product with an int8 weight fits 18b signed
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [9:0]  w_term;
            logic [17:0] w_term_x;
            logic [17:0] w_filt_x;
            assign w_term   = {{2{in_act[8*gi+7]}}, in_act[8*gi +: 8]}
                            + {input_offset[8], input_offset};
            assign w_term_x = {{8{w_term[9]}}, w_term};
            assign w_filt_x = {{10{in_filt[8*gi+7]}}, in_filt[8*gi +: 8]};
            assign w_prod[gi] = w_term_x * w_filt_x;
        end
    endgenerate

    always_comb begin
        w_lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_lane_sum = w_lane_sum + {{2{r_prod[i][17]}}, r_prod[i]};
        end
    end

    assign w_acc_inc = {{(ACC_W-20){w_lane_sum[19]}}, w_lane_sum};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_ACCUM: if (w_accept && in_last) w_state_next = ST_DRAIN;
            ST_DRAIN: w_state_next = (r_p_valid && r_p_last) ? ST_HOLD : ST_ACCUM;
            ST_HOLD:  if (acc_ready) w_state_next = ST_ACCUM;
            default:  w_state_next = ST_ACCUM;
        endcase
        // A beat accepted alongside clear starts the new sequence
        if (clear) begin
            w_state_next = (w_accept && in_last) ? ST_DRAIN : ST_ACCUM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p_valid <= 1'b0;
            r_p_last  <= 1'b0;
            r_acc     <= '0;
            r_beats   <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_prod[i] <= '0;
            end
        end else begin
            r_p_valid <= w_accept;
            if (w_accept) begin
                r_p_last <= in_last;
                for (int i = 0; i < LANES; i++) begin
                    r_prod[i] <= w_prod[i];
                end
            end
            if (clear || w_release) begin
                r_acc   <= '0;
                r_beats <= '0;
            end else if (r_p_valid) begin
                r_acc <= r_acc + w_acc_inc;
                if (r_beats != c_BEATS_MAX) begin
                    r_beats <= r_beats + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cfu_mac_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_cfu_mac_accumulator
// Brief    : Self-checking bench for cfu_mac_accumulator against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cfu_mac_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  input_offset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_act;
    logic [31:0] in_filt;
    logic        in_last;
    logic        clear;
    logic        acc_valid;
    logic        acc_ready;
    logic [31:0] acc_out;
    logic [15:0] acc_beats;

    int errors = 0;
    int checks = 0;

    cfu_mac_accumulator #(.LANES(4), .ACC_W(32), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .input_offset (input_offset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_act       (in_act),
        .in_filt      (in_filt),
        .in_last      (in_last),
        .clear        (clear),
        .acc_valid    (acc_valid),
        .acc_ready    (acc_ready),
        .acc_out      (acc_out),
        .acc_beats    (acc_beats)
    );

    always #5 clk = ~clk;

    // Dot product of one beat: sum over lanes of (act + offset) * filt
    function automatic int beat_val(logic [31:0] a, logic [31:0] f, logic [8:0] o);
        int s = 0;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] ab;
            logic [7:0] fb;
            ab = a[8*i +: 8];
            fb = f[8*i +: 8];
            s += (int'($signed(ab)) + int'($signed(o))) * int'($signed(fb));
        end
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(logic [31:0] a, logic [31:0] f, logic [8:0] o, logic last);
        in_valid     = 1'b1;
        in_act       = a;
        in_filt      = f;
        input_offset = o;
        in_last      = last;
        step();
    endtask

    // Called right after the in_last beat's accepting edge; n = cycles to acc_valid
    task automatic wait_valid(output int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        n = 1;
        while (!acc_valid && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic release_result();
        acc_ready = 1'b1;
        step();
        acc_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_act = '0; in_filt = '0; in_last = 1'b0;
        clear = 1'b0; acc_ready = 1'b0; input_offset = '0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready actual=%b required=0", in_ready); end
        step(); step();
        checks++;
        if (acc_valid !== 1'b0 || acc_out !== 32'd0 || acc_beats !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs actual valid=%b out=%0d beats=%0d required 0/0/0", acc_valid, acc_out, acc_beats);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready actual=%b required=1", in_ready); end
    endtask

    task automatic test_single();
        int n;
        send_beat(32'h01020304, 32'h01010101, 9'd128, 1'b1);
        wait_valid(n);
        checks++;
        if (n !== 2) begin errors++; $display("FAIL t1_latency actual=%0d required=2", n); end
        checks++;
        if ($signed(acc_out) !== 522 || acc_beats !== 16'd1) begin
            errors++; $display("FAIL t1_result actual=%0d/%0d required=522/1", $signed(acc_out), acc_beats);
        end
        release_result();
    endtask

    task automatic test_extremes();
        int n;
        send_beat(32'h80808080, 32'h80808080, 9'd127, 1'b1);
        wait_valid(n);
        checks++;
        if ($signed(acc_out) !== 512) begin errors++; $display("FAIL t2_neg_neg actual=%0d required=512", $signed(acc_out)); end
        release_result();
        send_beat(32'h7F7F7F7F, 32'h80808080, 9'd128, 1'b1);
        wait_valid(n);
        checks++;
        if (acc_out !== 32'hFFFE0200) begin errors++; $display("FAIL t2_pos_neg actual=%h required=fffe0200", acc_out); end
        release_result();
    endtask

    task automatic test_back_to_back();
        acc_ready = 1'b1;
        send_beat(32'h01020304, 32'h01010101, 9'd128, 1'b0);
        send_beat(32'h01020304, 32'h01010101, 9'd128, 1'b0);
        send_beat(32'h01020304, 32'h01010101, 9'd128, 1'b1);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL t3_drain_ready actual=%b required=0", in_ready); end
        step();
        checks++;
        if (in_ready !== 1'b0 || acc_valid !== 1'b1 || $signed(acc_out) !== 1566 || acc_beats !== 16'd3) begin
            errors++;
            $display("FAIL t3_hold actual ready=%b valid=%b out=%0d beats=%0d required 0/1/1566/3",
                     in_ready, acc_valid, $signed(acc_out), acc_beats);
        end
        in_valid = 1'b0; in_last = 1'b0;
        step();
        acc_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || acc_valid !== 1'b0) begin
            errors++; $display("FAIL t3_resume actual ready=%b valid=%b required 1/0", in_ready, acc_valid);
        end
    endtask

    task automatic test_backpressure();
        int n;
        int bad = 0;
        send_beat(32'h01020304, 32'h01010101, 9'd128, 1'b1);
        wait_valid(n);
        in_valid = 1'b1; in_act = 32'h7F7F7F7F; in_filt = 32'h7F7F7F7F;
        for (int i = 0; i < 10; i++) begin
            if (acc_valid !== 1'b1 || $signed(acc_out) !== 522 || acc_beats !== 16'd1 || in_ready !== 1'b0) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL t4_stall_stable actual=%0d bad cycles required=0", bad); end
        in_valid = 1'b0;
        release_result();
        test_single();
    endtask

    task automatic test_clear();
        int n;
        send_beat(32'h11223344, 32'h05060708, 9'd3, 1'b0);
        send_beat(32'h55667788, 32'h01020304, 9'd7, 1'b0);
        clear = 1'b1;
        send_beat(32'h01020304, 32'h01010101, 9'd128, 1'b1);
        clear = 1'b0;
        wait_valid(n);
        checks++;
        if ($signed(acc_out) !== 522 || acc_beats !== 16'd1 || n !== 2) begin
            errors++; $display("FAIL t5_clear_collision actual=%0d/%0d lat=%0d required=522/1/2", $signed(acc_out), acc_beats, n);
        end
        release_result();
    endtask

    task automatic test_async_reset();
        int seen = 0;
        send_beat(32'h7F7F7F7F, 32'h7F7F7F7F, 9'd100, 1'b0);
        send_beat(32'h7F7F7F7F, 32'h7F7F7F7F, 9'd100, 1'b0);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (acc_out !== 32'd0 || acc_beats !== 16'd0 || acc_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL t6_async_reset actual out=%0d beats=%0d valid=%b ready=%b required 0/0/0/0",
                                acc_out, acc_beats, acc_valid, in_ready);
        end
        step();
        #2;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (acc_valid !== 1'b0 || acc_out !== 32'd0) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL t6_no_stale actual=%0d bad cycles required=0", seen); end
        test_single();
    endtask

    task automatic test_random();
        for (int s = 0; s < 30; s++) begin
            int len = $urandom_range(1, 8);
            logic [8:0] off = 9'($urandom_range(0, 511));
            int expv = 0;
            int n;
            for (int b = 0; b < len; b++) begin
                logic [31:0] a = $urandom;
                logic [31:0] f = $urandom;
                if ($urandom_range(0, 3) == 0) begin
                    in_valid = 1'b0;
                    step();
                end
                expv += beat_val(a, f, off);
                send_beat(a, f, off, (b == len - 1));
            end
            wait_valid(n);
            checks++;
            if (n !== 2 || acc_out !== expv || acc_beats !== 16'(len)) begin
                errors++;
                $display("FAIL rand_seq%0d actual=%h/%0d lat=%0d required=%h/%0d lat=2", s, acc_out, acc_beats, n, expv, len);
            end
            repeat ($urandom_range(0, 3)) step();
            release_result();
        end
    endtask

    task automatic test_saturation();
        int n;
        for (int b = 0; b < 65536; b++) begin
            send_beat(32'h01010101, 32'h01010101, 9'd0, (b == 65535));
        end
        wait_valid(n);
        checks++;
        if (acc_valid !== 1'b1 || acc_beats !== 16'hFFFF || acc_out !== 32'd262144) begin
            errors++; $display("FAIL beat_saturation actual valid=%b beats=%h out=%0d required 1/ffff/262144",
                                acc_valid, acc_beats, acc_out);
        end
        release_result();
    endtask

    initial begin
        test_reset();
        test_single();
        test_extremes();
        test_back_to_back();
        test_backpressure();
        test_clear();
        test_async_reset();
        test_random();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
